// File: rtl/dance_pkg.sv
// Shared gameplay types and constants for the arrow lane engine and the VGA arrow renderer.
package dance_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        FLASH  = 2'd2
    } lane_state_e;

    localparam int NUM_LANES  = 4;
    localparam int LANE_LEFT  = 3;
    localparam int LANE_DOWN  = 2;
    localparam int LANE_UP    = 1;
    localparam int LANE_RIGHT = 0;

    localparam int DELTA_W = 9;

    localparam int unsigned DEF_START_Y = 408;
    localparam int unsigned DEF_HIT_WIN = 24;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/arrow_lane_engine_if.sv
// Pad/spawn inputs and per-lane gameplay outputs of arrow_lane_engine.
// PERFECT_GRADE_EN adds the perfect_pulse strobe.
interface arrow_lane_engine_if;

    logic [3:0]                                   pad;
    logic [3:0]                                   lane_spawn;
    logic                                         pause;
    logic [dance_pkg::NUM_LANES*dance_pkg::DELTA_W-1:0] delta_y;
    logic [3:0]                                   lane_active;
    logic [3:0]                                   lane_flash;
    logic [3:0]                                   hit_pulse;
    logic [3:0]                                   miss_pulse;
    logic [15:0]                                  score;
    logic [7:0]                                   combo;
    logic                                         tick;
`ifdef PERFECT_GRADE_EN
    logic [3:0]                                   perfect_pulse;
`endif

    modport slave (
        input  pad, lane_spawn, pause,
        output delta_y, lane_active, lane_flash, hit_pulse, miss_pulse, score, combo, tick
`ifdef PERFECT_GRADE_EN
        , output perfect_pulse
`endif
    );

    modport master (
        output pad, lane_spawn, pause,
        input  delta_y, lane_active, lane_flash, hit_pulse, miss_pulse, score, combo, tick
`ifdef PERFECT_GRADE_EN
        , input perfect_pulse
`endif
    );

endinterface

// File: rtl/arrow_lane.sv
// One lane: IDLE/SCROLL/FLASH state machine, vertical offset and flash tick counter.
// PERFECT_GRADE_EN adds the perfect-grade strobe.
module arrow_lane
    import dance_pkg::*;
#(
    parameter int unsigned START_Y     = DEF_START_Y,
    parameter int unsigned HIT_WIN     = DEF_HIT_WIN,
    parameter int unsigned FLASH_TICKS = 8
`ifdef PERFECT_GRADE_EN
    , parameter int unsigned PERFECT_WIN = 6
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spawn,
    input  logic               press,
    input  logic               tick,
    output logic [DELTA_W-1:0] delta,
    output logic               active,
    output logic               flash,
    output logic               hit,
    output logic               miss
`ifdef PERFECT_GRADE_EN
    , output logic             perfect
`endif
);

    localparam int FC_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [DELTA_W-1:0] START_D  = DELTA_W'(START_Y);
    localparam logic [DELTA_W-1:0] HIT_D    = DELTA_W'(HIT_WIN);
    localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(FLASH_TICKS - 1);
`ifdef PERFECT_GRADE_EN
    localparam logic [DELTA_W-1:0] PERFECT_D = DELTA_W'(PERFECT_WIN);
    logic perfect_next;
`endif

    lane_state_e        state, state_next;
    logic [DELTA_W-1:0] delta_next;
    logic [FC_W-1:0]    fcnt, fcnt_next;
    logic               hit_next, miss_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            delta <= START_D;
            fcnt  <= '0;
            hit   <= 1'b0;
            miss  <= 1'b0;
`ifdef PERFECT_GRADE_EN
            perfect <= 1'b0;
`endif
        end else begin
            state <= state_next;
            delta <= delta_next;
            fcnt  <= fcnt_next;
            hit   <= hit_next;
            miss  <= miss_next;
`ifdef PERFECT_GRADE_EN
            perfect <= perfect_next;
`endif
        end
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        delta_next = delta;
        fcnt_next  = fcnt;
        hit_next   = 1'b0;
        miss_next  = 1'b0;
`ifdef PERFECT_GRADE_EN
        perfect_next = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (spawn) begin
                    state_next = SCROLL;
                    delta_next = START_D;
                end
            end
            SCROLL: begin
                // A hit beats a same-cycle tick, so the offset is held on the judging edge.
                if (press && (delta <= HIT_D)) begin
                    hit_next   = 1'b1;
                    state_next = FLASH;
                    fcnt_next  = '0;
`ifdef PERFECT_GRADE_EN
                    perfect_next = (delta <= PERFECT_D);
`endif
                end else if (tick) begin
                    if (delta == '0) begin
                        miss_next  = 1'b1;
                        state_next = IDLE;
                        delta_next = START_D;
                    end else begin
                        delta_next = delta - 1'b1;
                    end
                end
            end
            FLASH: begin
                if (tick) begin
                    if (fcnt == FC_LAST) begin
                        state_next = IDLE;
                        delta_next = START_D;
                    end else begin
                        fcnt_next = fcnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign active = (state == SCROLL);
    assign flash  = (state == FLASH);

endmodule

// File: rtl/arrow_lane_engine.sv
// Four-lane arrow gameplay stage: pad synchronizer, scroll tick divider, lanes, score and combo.
// Optional macro PERFECT_GRADE_EN adds perfect_pulse and double scoring for perfect hits.
module arrow_lane_engine
    import dance_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 500000,
    parameter int unsigned START_Y     = DEF_START_Y,
    parameter int unsigned HIT_WIN     = DEF_HIT_WIN,
    parameter int unsigned FLASH_TICKS = 8
`ifdef PERFECT_GRADE_EN
    , parameter int unsigned PERFECT_WIN = 6
`endif
) (
    input logic               clk,
    input logic               rst_n,
    arrow_lane_engine_if.slave bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [3:0]                   pad_meta, pad_sync, pad_last;
    logic [CNT_W-1:0]             div_cnt;
    logic                         tick_c;
    logic [3:0]                   press_g, spawn_g;
    logic [NUM_LANES*DELTA_W-1:0] delta_v;
    logic [3:0]                   active_v, flash_v, hit_v, miss_v, perf_v;
    logic [15:0]                  score, score_next;
    logic [7:0]                   combo, combo_next;
    logic [2:0]                   hit_cnt;
    logic [3:0]                   points;
    logic [16:0]                  score_sum;
    logic [8:0]                   combo_sum;

    // pad_last is the edge register behind the two synchronizer flops; released pads read 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_meta <= '1;
            pad_sync <= '1;
            pad_last <= '1;
            div_cnt  <= '0;
            score    <= '0;
            combo    <= '0;
        end else begin
            pad_meta <= bus.pad;
            pad_sync <= pad_meta;
            pad_last <= pad_sync;
            if (!bus.pause) div_cnt <= tick_c ? '0 : div_cnt + 1'b1;
            score <= score_next;
            combo <= combo_next;
        end
    end

    assign tick_c  = !bus.pause && (div_cnt == CNT_LAST);
    assign press_g = bus.pause ? 4'h0 : (pad_last & ~pad_sync);
    assign spawn_g = bus.pause ? 4'h0 : bus.lane_spawn;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        arrow_lane #(
            .START_Y    (START_Y),
            .HIT_WIN    (HIT_WIN),
            .FLASH_TICKS(FLASH_TICKS)
`ifdef PERFECT_GRADE_EN
            , .PERFECT_WIN(PERFECT_WIN)
`endif
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .spawn (spawn_g[n]),
            .press (press_g[n]),
            .tick  (tick_c),
            .delta (delta_v[n*DELTA_W +: DELTA_W]),
            .active(active_v[n]),
            .flash (flash_v[n]),
            .hit   (hit_v[n]),
            .miss  (miss_v[n])
`ifdef PERFECT_GRADE_EN
            , .perfect(perf_v[n])
`endif
        );
    end

`ifndef PERFECT_GRADE_EN
    assign perf_v = 4'h0;
`endif

    // A perfect is worth one extra point on top of its hit.
    always_comb begin
        hit_cnt   = popcount4(hit_v);
        points    = 4'(hit_cnt) + 4'(popcount4(perf_v));
        score_sum = {1'b0, score} + 17'(points);
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        combo_sum = {1'b0, combo} + 9'(hit_cnt);
        if (|miss_v) combo_next = 8'(hit_cnt);
        else         combo_next = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end

    assign bus.delta_y     = delta_v;
    assign bus.lane_active = active_v;
    assign bus.lane_flash  = flash_v;
    assign bus.hit_pulse   = hit_v;
    assign bus.miss_pulse  = miss_v;
    assign bus.score       = score;
    assign bus.combo       = combo;
    assign bus.tick        = tick_c;
`ifdef PERFECT_GRADE_EN
    assign bus.perfect_pulse = perf_v;
`endif

endmodule

// File: tb/tb_arrow_lane_engine.sv
// Self-checking bench for arrow_lane_engine: directed gameplay scenarios plus random play,
// every cycle compared against a lane-level behavioural model.
module tb_arrow_lane_engine;
    import dance_pkg::*;

    localparam int TB_TICK_DIV    = 4;
    localparam int TB_START_Y     = 16;
    localparam int TB_HIT_WIN     = 3;
    localparam int TB_FLASH_TICKS = 2;
    localparam int TB_PERFECT_WIN = 1;

    logic clk = 1'b0;
    logic rst_n;

    arrow_lane_engine_if bus_if ();

    arrow_lane_engine #(
        .TICK_DIV   (TB_TICK_DIV),
        .START_Y    (TB_START_Y),
        .HIT_WIN    (TB_HIT_WIN),
        .FLASH_TICKS(TB_FLASH_TICKS)
`ifdef PERFECT_GRADE_EN
        , .PERFECT_WIN(TB_PERFECT_WIN)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: mode 0 = idle, 1 = scrolling, 2 = flashing; m_left counts flash ticks remaining.
    int         m_cnt;
    int         m_mode [4];
    int         m_off  [4];
    int         m_left [4];
    logic [3:0] m_hist [3];
    logic [3:0] m_hit, m_miss, m_perf;
    int         m_score, m_combo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] press, hit, miss, perf;
        bit         tk;
        int         hits;
        hit  = '0;
        miss = '0;
        perf = '0;
        if (!rst_n) begin
            m_cnt = 0;
            for (int n = 0; n < 4; n++) begin
                m_mode[n] = 0;
                m_off[n]  = TB_START_Y;
                m_left[n] = 0;
            end
            for (int i = 0; i < 3; i++) m_hist[i] = 4'hF;
            m_hit   = '0;
            m_miss  = '0;
            m_perf  = '0;
            m_score = 0;
            m_combo = 0;
            return;
        end
        hits = $countones(m_hit);
        m_score = m_score + hits + $countones(m_perf);
        if (m_score > 65535) m_score = 65535;
        if (m_miss != 0) m_combo = hits;
        else begin
            m_combo = m_combo + hits;
            if (m_combo > 255) m_combo = 255;
        end
        tk    = !bus_if.pause && (m_cnt == TB_TICK_DIV - 1);
        press = bus_if.pause ? 4'h0 : (~m_hist[1] & m_hist[2]);
        for (int n = 0; n < 4; n++) begin
            case (m_mode[n])
                0: if (bus_if.lane_spawn[n] && !bus_if.pause) begin
                    m_mode[n] = 1;
                    m_off[n]  = TB_START_Y;
                end
                1: if (press[n] && m_off[n] <= TB_HIT_WIN) begin
                    hit[n]    = 1'b1;
`ifdef PERFECT_GRADE_EN
                    perf[n]   = (m_off[n] <= TB_PERFECT_WIN);
`endif
                    m_mode[n] = 2;
                    m_left[n] = TB_FLASH_TICKS;
                end else if (tk) begin
                    if (m_off[n] == 0) begin
                        miss[n]   = 1'b1;
                        m_mode[n] = 0;
                        m_off[n]  = TB_START_Y;
                    end else m_off[n]--;
                end
                default: if (tk) begin
                    m_left[n]--;
                    if (m_left[n] == 0) begin
                        m_mode[n] = 0;
                        m_off[n]  = TB_START_Y;
                    end
                end
            endcase
        end
        m_hit  = hit;
        m_miss = miss;
        m_perf = perf;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = bus_if.pad;
        if (!bus_if.pause) m_cnt = tk ? 0 : m_cnt + 1;
    endtask

    task automatic compare_all();
        logic [35:0] ed;
        logic [3:0]  ea, ef;
        for (int n = 0; n < 4; n++) begin
            ed[n*9 +: 9] = 9'(m_off[n]);
            ea[n] = (m_mode[n] == 1);
            ef[n] = (m_mode[n] == 2);
        end
        check("delta_y", 64'(bus_if.delta_y), 64'(ed));
        check("lane_active", 64'(bus_if.lane_active), 64'(ea));
        check("lane_flash", 64'(bus_if.lane_flash), 64'(ef));
        check("hit_pulse", 64'(bus_if.hit_pulse), 64'(m_hit));
        check("miss_pulse", 64'(bus_if.miss_pulse), 64'(m_miss));
        check("score", 64'(bus_if.score), 64'(m_score));
        check("combo", 64'(bus_if.combo), 64'(m_combo));
        check("tick", 64'(bus_if.tick), 64'(!bus_if.pause && m_cnt == TB_TICK_DIV - 1));
`ifdef PERFECT_GRADE_EN
        check("perfect_pulse", 64'(bus_if.perfect_pulse), 64'(m_perf));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        cyc++;
    endtask

    // Advance until the model lane sits at offset val right after a tick (bounded).
    task automatic wait_off(input int lane, input int val);
        int i = 0;
        while (!(m_mode[lane] == 1 && m_off[lane] == val && m_cnt == 0) && i < 300) begin
            step();
            i++;
        end
        check("wait_off", 64'(bus_if.delta_y[lane*9 +: 9]), 64'(val));
    endtask

    initial begin
        int         lat, cnt, s0, c0;
        bit         seen;
        logic [3:0] acc, padv;

        rst_n             = 1'b0;
        bus_if.pad        = 4'hF;
        bus_if.lane_spawn = 4'h0;
        bus_if.pause      = 1'b0;
        repeat (3) step();
        check("reset_delta", 64'(bus_if.delta_y), 64'({4{9'd16}}));
        check("reset_active", 64'(bus_if.lane_active), 64'h0);
        rst_n = 1'b1;

        lat = 1;
        while (!bus_if.tick && lat < 10) begin
            step();
            lat++;
        end
        check("tick_latency", 64'(lat), 64'd4);

        // Miss on lane 3
        bus_if.lane_spawn = 4'b1000;
        step();
        bus_if.lane_spawn = 4'h0;
        seen = 0;
        for (int i = 0; i < 120 && !seen; i++) begin
            step();
            if (bus_if.miss_pulse[3]) seen = 1;
        end
        check("miss_seen", 64'(seen), 64'd1);
        step();
        check("miss_one_cycle", 64'(bus_if.miss_pulse[3]), 64'd0);
        check("miss_inactive", 64'(bus_if.lane_active[3]), 64'd0);
        check("miss_combo", 64'(bus_if.combo), 64'd0);

        // Early press ignored, then hit at offset 3
        bus_if.lane_spawn = 4'b1000;
        step();
        bus_if.lane_spawn = 4'h0;
        wait_off(3, 10);
        bus_if.pad[3] = 1'b0;
        repeat (3) step();
        bus_if.pad[3] = 1'b1;
        repeat (4) step();
        check("early_no_flash", 64'(bus_if.lane_flash[3]), 64'd0);
        check("early_active", 64'(bus_if.lane_active[3]), 64'd1);
        wait_off(3, 3);
        s0 = m_score;
        c0 = m_combo;
        bus_if.pad[3] = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_if.hit_pulse[3]) seen = 1;
        end
        bus_if.pad[3] = 1'b1;
        check("hit_seen", 64'(seen), 64'd1);
        check("hit_flash", 64'(bus_if.lane_flash[3]), 64'd1);
        check("hit_score", 64'(bus_if.score), 64'(s0 + 1));
        check("hit_combo", 64'(bus_if.combo), 64'(c0 + 1));
        repeat (12) step();

        // Simultaneous hits on all lanes, pads then held low for 50 cycles
        bus_if.lane_spawn = 4'hF;
        step();
        bus_if.lane_spawn = 4'h0;
        wait_off(0, 2);
        s0 = m_score;
        c0 = m_combo;
        bus_if.pad = 4'h0;
        acc = '0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            acc |= bus_if.hit_pulse;
            cnt += $countones(bus_if.hit_pulse);
            if (i == 3) begin
                check("simul_score", 64'(bus_if.score), 64'(s0 + 4));
                check("simul_combo", 64'(bus_if.combo), 64'(c0 + 4));
            end
        end
        bus_if.pad = 4'hF;
        check("simul_hits", 64'(acc), 64'hF);
        check("simul_hit_count", 64'(cnt), 64'd4);
        repeat (10) step();

        // Held pad pressed too early never turns into a late hit
        bus_if.lane_spawn = 4'b0010;
        step();
        bus_if.lane_spawn = 4'h0;
        wait_off(1, 4);
        bus_if.pad[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            cnt += int'(bus_if.hit_pulse[1]);
        end
        bus_if.pad[1] = 1'b1;
        check("held_no_hit", 64'(cnt), 64'd0);

        // Pause freezes scrolling and ignores presses
        bus_if.lane_spawn = 4'b0100;
        step();
        bus_if.lane_spawn = 4'h0;
        wait_off(2, 8);
        s0 = m_off[2];
        bus_if.pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus_if.pad[2] = (i >= 5 && i < 10) ? 1'b0 : 1'b1;
            step();
        end
        check("pause_delta", 64'(bus_if.delta_y[18 +: 9]), 64'(s0));
        check("pause_active", 64'(bus_if.lane_active[2]), 64'd1);
        bus_if.pause = 1'b0;
        repeat (2) step();

        // Reset with lane 2 still scrolling
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_inactive", 64'(bus_if.lane_active[2]), 64'd0);
        check("rst_no_miss", 64'(bus_if.miss_pulse), 64'd0);
        step();
        check("rst_no_miss_after", 64'(bus_if.miss_pulse), 64'd0);

`ifdef PERFECT_GRADE_EN
        for (int k = 0; k < 2; k++) begin
            bus_if.lane_spawn = 4'b0100;
            step();
            bus_if.lane_spawn = 4'h0;
            wait_off(2, (k == 0) ? 1 : 3);
            s0 = m_score;
            bus_if.pad[2] = 1'b0;
            seen = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (bus_if.perfect_pulse[2]) seen = 1;
            end
            bus_if.pad[2] = 1'b1;
            check("perfect_seen", 64'(seen), (k == 0) ? 64'd1 : 64'd0);
            check("perfect_score", 64'(bus_if.score), 64'(s0 + ((k == 0) ? 2 : 1)));
            repeat (12) step();
        end
`endif

        // Random play
        for (int i = 0; i < 4000; i++) begin
            bus_if.lane_spawn = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 5) == 0) begin
                padv = bus_if.pad;
                padv[$urandom_range(0, 3)] = ~padv[$urandom_range(0, 3)];
                bus_if.pad = padv;
            end
            if (bus_if.pause) bus_if.pause = ($urandom_range(0, 3) != 0);
            else              bus_if.pause = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n             = 1'b1;
        bus_if.pause      = 1'b0;
        bus_if.lane_spawn = 4'h0;
        bus_if.pad        = 4'hF;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
